// File: rtl/aes_pkg.sv
// Shared AES-128 types, round constants and byte-level transforms.
// Byte 0 of every 128-bit word sits in bits [127:120].
package aes_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ROUND,
    FINAL,
    DONE
  } state_e;

  localparam int NUM_ROUNDS = 10;

  function automatic logic [7:0] get_rcon(input logic [3:0] r);
    logic [7:0] v;
    unique case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gmul(
    input logic [7:0] a,
    input logic [7:0] b
  );
    logic [7:0] p;
    logic [7:0] x;
    p = '0;
    x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = xtime(x);
    end
    return p;
  endfunction

  // Inverse as b^254 (0 maps to 0), then the affine map.
  function automatic logic [7:0] sbox(input logic [7:0] b);
    logic [7:0] sq;
    logic [7:0] v;
    sq = b;
    v  = 8'h01;
    for (int k = 1; k < 8; k++) begin
      sq = gmul(sq, sq);
      v  = gmul(v, sq);
    end
    return v ^ {v[6:0], v[7]} ^ {v[5:0], v[7:6]}
             ^ {v[4:0], v[7:5]} ^ {v[3:0], v[7:4]} ^ 8'h63;
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]),
            sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int i = 0; i < 16; i++)
      o[8*i +: 8] = sbox(s[8*i +: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c+r)%4)+r) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)
      };
    end
    return o;
  endfunction

endpackage

// File: rtl/aes_key_step.sv
// One AES-128 key-schedule step: previous round key to next.
// Purely combinational; rcon enters the top byte of the first word.
module aes_key_step
  import aes_pkg::*;
(
  input  logic [127:0] key_in,
  input  logic [7:0]   rcon,
  output logic [127:0] key_out
);

  logic [31:0] t;
  logic [31:0] n0, n1, n2, n3;

  assign t  = sub_word({key_in[23:0], key_in[31:24]})
            ^ {rcon, 24'h0};
  assign n0 = key_in[127:96] ^ t;
  assign n1 = key_in[95:64]  ^ n0;
  assign n2 = key_in[63:32]  ^ n1;
  assign n3 = key_in[31:0]   ^ n2;

  assign key_out = {n0, n1, n2, n3};

endmodule

// File: rtl/encrypt_final_round.sv
// Last AES round datapath.
// Same as a full round but without MixColumns.
module encrypt_final_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);

  assign state_out = shift_rows(sub_bytes(state_in)) ^ round_key;

endmodule

// File: rtl/encrypt_round.sv
// Full AES round datapath.
// SubBytes, ShiftRows, MixColumns, then AddRoundKey.
module encrypt_round
  import aes_pkg::*;
(
  input  logic [127:0] state_in,
  input  logic [127:0] round_key,
  output logic [127:0] state_out
);

  assign state_out =
    mix_columns(shift_rows(sub_bytes(state_in))) ^ round_key;

endmodule

// File: rtl/aes_encrypt_ctrl.sv
// Iterative AES-128 encryptor: one round per clock,
// valid/ready on both sides, optional zeroize on output.
module aes_encrypt_ctrl
  import aes_pkg::*;
#(
  parameter bit ZEROIZE = 1'b1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] in_key,
  input  logic [127:0] in_data,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         busy,
  output logic [3:0]   round_cnt
);

  state_e       state;
  logic [127:0] state_reg;
  logic [127:0] key_reg;
  logic [127:0] nk;
  logic [127:0] rnd_out;
  logic [127:0] fin_out;
  logic [3:0]   rcnt;
  logic [7:0]   rc;

  assign rc = get_rcon(rcnt);

  aes_key_step u_key_step (
    .key_in  (key_reg),
    .rcon    (rc),
    .key_out (nk)
  );

  encrypt_round u_round (
    .state_in  (state_reg),
    .round_key (nk),
    .state_out (rnd_out)
  );

  encrypt_final_round u_final (
    .state_in  (state_reg),
    .round_key (nk),
    .state_out (fin_out)
  );

  // Control FSM plus state/key/round registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state     <= IDLE;
      rcnt      <= '0;
      state_reg <= '0;
      key_reg   <= '0;
    end else begin
      unique case (state)
        IDLE: if (in_valid) begin
          state_reg <= in_data ^ in_key;
          key_reg   <= in_key;
          rcnt      <= 4'd1;
          state     <= ROUND;
        end
        ROUND: begin
          key_reg   <= nk;
          state_reg <= rnd_out;
          rcnt      <= rcnt + 4'd1;
          if (rcnt == 4'(NUM_ROUNDS - 1))
            state <= FINAL;
        end
        FINAL: begin
          key_reg   <= nk;
          state_reg <= fin_out;
          rcnt      <= 4'(NUM_ROUNDS);
          state     <= DONE;
        end
        DONE: if (out_ready) begin
          state <= IDLE;
          rcnt  <= '0;
          if (ZEROIZE) begin
            state_reg <= '0;
            key_reg   <= '0;
          end
        end
      endcase
    end
  end

  assign in_ready  = rst_n && (state == IDLE);
  assign out_valid = (state == DONE);
  assign busy      = (state != IDLE);
  assign round_cnt = rcnt;
  assign out_data  = (ZEROIZE && !out_valid) ? '0 : state_reg;

endmodule

// File: tb/tb_aes_encrypt_ctrl.sv
// Bench for aes_encrypt_ctrl: FIPS vectors, backpressure,
// reset abort, back-to-back and random traffic vs. a model.
module tb_aes_encrypt_ctrl;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         out_ready;
  logic [127:0] in_key;
  logic [127:0] in_data;

  logic         in_ready, out_valid, busy;
  logic [127:0] out_data;
  logic [3:0]   round_cnt;

  logic         z_in_ready, z_out_valid, z_busy;
  logic [127:0] z_out_data;
  logic [3:0]   z_round_cnt;

  int errors = 0;
  int checks = 0;

  logic [7:0] sb [0:255];

  localparam logic [127:0] KB  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] PB  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] CB  = 128'h3925841d02dc09fbdc118597196a0b32;
  localparam logic [127:0] LKB = 128'hd014f9a8c9ee2589e13f0cc8b6630ca6;
  localparam logic [127:0] KC  = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] PC  = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] CC  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;

  always #5 clk = ~clk;

  aes_encrypt_ctrl dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .busy      (busy),
    .round_cnt (round_cnt)
  );

  aes_encrypt_ctrl #(.ZEROIZE(1'b0)) dut0 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (z_in_ready),
    .in_key    (in_key),
    .in_data   (in_data),
    .out_valid (z_out_valid),
    .out_ready (out_ready),
    .out_data  (z_out_data),
    .busy      (z_busy),
    .round_cnt (z_round_cnt)
  );

  task automatic chk(input string tag,
                     input logic [127:0] obs,
                     input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // S-box from the generator-3 walk over GF(2^8).
  task automatic build_sbox;
    logic [7:0] p, q, x;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ {p[6:0], 1'b0} ^ (p[7] ? 8'h1b : 8'h00);
      q = q ^ {q[6:0], 1'b0};
      q = q ^ {q[5:0], 2'b0};
      q = q ^ {q[3:0], 4'b0};
      if (q[7]) q = q ^ 8'h09;
      x = q ^ {q[6:0], q[7]} ^ {q[5:0], q[7:6]}
            ^ {q[4:0], q[7:5]} ^ {q[3:0], q[7:4]};
      sb[p] = x ^ 8'h63;
    end while (p != 8'h01);
    sb[0] = 8'h63;
  endtask

  function automatic logic [7:0] xt(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // Textbook AES-128 on byte arrays with full key expansion.
  task automatic aes_ref(input  logic [127:0] key,
                         input  logic [127:0] pt,
                         output logic [127:0] ct,
                         output logic [127:0] lastkey);
    logic [31:0] w [0:43];
    logic [7:0]  s [0:15];
    logic [7:0]  t [0:15];
    logic [31:0] tmp;
    logic [7:0]  rcv;
    rcv = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      tmp = w[i-1];
      if (i % 4 == 0) begin
        tmp = {sb[tmp[23:16]], sb[tmp[15:8]],
               sb[tmp[7:0]], sb[tmp[31:24]]} ^ {rcv, 24'h0};
        rcv = xt(rcv);
      end
      w[i] = w[i-4] ^ tmp;
    end
    for (int j = 0; j < 16; j++)
      s[j] = pt[127-8*j -: 8] ^ w[j/4][31-8*(j%4) -: 8];
    for (int r = 1; r <= 10; r++) begin
      for (int j = 0; j < 16; j++) s[j] = sb[s[j]];
      for (int c = 0; c < 4; c++)
        for (int row = 0; row < 4; row++)
          t[4*c+row] = s[4*((c+row)%4)+row];
      for (int c = 0; c < 4; c++) begin
        if (r < 10) begin
          s[4*c]   = xt(t[4*c]) ^ xt(t[4*c+1]) ^ t[4*c+1]
                   ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+1] = t[4*c] ^ xt(t[4*c+1]) ^ xt(t[4*c+2])
                   ^ t[4*c+2] ^ t[4*c+3];
          s[4*c+2] = t[4*c] ^ t[4*c+1] ^ xt(t[4*c+2])
                   ^ xt(t[4*c+3]) ^ t[4*c+3];
          s[4*c+3] = xt(t[4*c]) ^ t[4*c] ^ t[4*c+1]
                   ^ t[4*c+2] ^ xt(t[4*c+3]);
        end else begin
          for (int k = 0; k < 4; k++) s[4*c+k] = t[4*c+k];
        end
      end
      for (int j = 0; j < 16; j++)
        s[j] = s[j] ^ w[4*r + j/4][31-8*(j%4) -: 8];
    end
    for (int j = 0; j < 16; j++) ct[127-8*j -: 8] = s[j];
    lastkey = {w[40], w[41], w[42], w[43]};
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  // Present a request and hold it until accepted.
  task automatic accept(input logic [127:0] k, input logic [127:0] d);
    int n;
    in_key   = k;
    in_data  = d;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 40) begin
      tick;
      n++;
    end
    chk("accept_timeout", 128'(in_ready), 128'(1'b1));
    tick;
    in_valid = 1'b0;
    in_key   = rnd128();
    in_data  = rnd128();
  endtask

  // Cycles from the accept cycle to first out_valid.
  task automatic wait_done(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      tick;
      lat++;
    end
  endtask

  task automatic handshake;
    out_ready = 1'b1;
    tick;
    out_ready = 1'b0;
  endtask

  logic [127:0] ct_m, lk_m, hold;
  logic [127:0] exp_q [$];
  int           lat, nv, ndone;
  int           tdone [0:2];

  initial begin
    build_sbox();
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_key    = '0;
    in_data   = '0;
    #1;
    chk("in_ready_in_reset", 128'(in_ready), 128'(1'b0));
    tick;
    tick;
    chk("rst_busy",      128'(busy),      128'(1'b0));
    chk("rst_out_valid", 128'(out_valid), 128'(1'b0));
    chk("rst_round_cnt", 128'(round_cnt), 128'(4'd0));
    chk("rst_out_data",  out_data,        128'h0);
    chk("rst_in_ready",  128'(in_ready),  128'(1'b0));
    rst_n = 1'b1;
    #1;
    chk("in_ready_after_rst", 128'(in_ready), 128'(1'b1));

    // App. B with latency, backpressure and zeroize
    accept(KB, PB);
    chk("b_round1",   128'(round_cnt), 128'(4'd1));
    chk("b_busy",     128'(busy),      128'(1'b1));
    chk("b_in_ready", 128'(in_ready),  128'(1'b0));
    chk("b_out_data_hidden", out_data, 128'h0);
    wait_done(lat);
    chk("b_latency", 128'(lat), 128'(11));
    chk("b_ct",      out_data,  CB);
    chk("b_ct_z0",   z_out_data, CB);
    chk("b_lastkey_z0", dut0.key_reg, LKB);
    for (int i = 0; i < 20; i++) begin
      in_valid = (i % 2 == 0);
      in_key   = rnd128();
      in_data  = rnd128();
      tick;
      chk("bp_valid", 128'(out_valid), 128'(1'b1));
      chk("bp_data",  out_data,        CB);
    end
    in_valid = 1'b0;
    handshake();
    chk("hs_out_valid", 128'(out_valid), 128'(1'b0));
    chk("hs_in_ready",  128'(in_ready),  128'(1'b1));
    chk("hs_round_cnt", 128'(round_cnt), 128'(4'd0));
    chk("hs_out_data",  out_data,        128'h0);
    chk("zero_state",   dut.state_reg,   128'h0);
    chk("zero_key",     dut.key_reg,     128'h0);
    chk("keep_key_z0",  dut0.key_reg,    LKB);
    chk("keep_data_z0", z_out_data,      CB);

    // App. C.1
    accept(KC, PC);
    wait_done(lat);
    chk("c_latency", 128'(lat), 128'(11));
    chk("c_ct",      out_data,  CC);
    handshake();

    // Reset in the middle of round 5
    accept(KB, PB);
    for (int i = 0; i < 4; i++) tick;
    chk("mid_round5", 128'(round_cnt), 128'(4'd5));
    rst_n = 1'b0;
    tick;
    rst_n = 1'b1;
    #1;
    chk("abort_in_ready",  128'(in_ready),  128'(1'b1));
    chk("abort_round_cnt", 128'(round_cnt), 128'(4'd0));
    chk("abort_busy",      128'(busy),      128'(1'b0));
    chk("abort_key",       dut.key_reg,     128'h0);
    nv = 0;
    for (int i = 0; i < 15; i++) begin
      if (out_valid) nv++;
      tick;
    end
    chk("abort_no_valid", 128'(nv), 128'(0));
    accept(KB, PB);
    wait_done(lat);
    chk("b2_ct", out_data, CB);
    handshake();

    // Random requests with random output stalls
    for (int n = 0; n < 4; n++) begin
      in_key  = rnd128();
      in_data = rnd128();
      aes_ref(in_key, in_data, ct_m, lk_m);
      accept(in_key, in_data);
      wait_done(lat);
      chk("rnd_latency", 128'(lat), 128'(11));
      chk("rnd_ct",      out_data,  ct_m);
      chk("rnd_lastkey", dut0.key_reg, lk_m);
      hold = out_data;
      for (int i = 0; i < int'($urandom_range(0, 3)); i++) tick;
      chk("rnd_hold", out_data, hold);
      handshake();
    end

    // Back-to-back with inputs changing every cycle
    out_ready = 1'b1;
    in_valid  = 1'b1;
    ndone = 0;
    for (int cyc = 0; cyc < 60 && ndone < 3; cyc++) begin
      in_key  = rnd128();
      in_data = rnd128();
      if (in_ready) begin
        aes_ref(in_key, in_data, ct_m, lk_m);
        exp_q.push_back(ct_m);
      end
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          chk("b2b_spurious", 128'(out_valid), 128'(1'b0));
        end else begin
          chk("b2b_ct", out_data, exp_q.pop_front());
        end
        tdone[ndone] = cyc;
        ndone++;
      end
      tick;
    end
    in_valid  = 1'b0;
    out_ready = 1'b0;
    chk("b2b_count", 128'(ndone), 128'(3));
    if (ndone == 3) begin
      chk("b2b_gap1", 128'(tdone[1] - tdone[0]), 128'(12));
      chk("b2b_gap2", 128'(tdone[2] - tdone[1]), 128'(12));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/aes_encrypt_ctrl.md
AES_ENCRYPT_CTRL -- requirements
Module: aes_encrypt_ctrl

Interface
REQ-001 Parameter ZEROIZE, default 1: when 1, clear the state and key registers on the output handshake.
REQ-002 clk  input  1  sole clock; all registers update on the rising edge.
REQ-003 rst_n  input  1  reset, synchronous and active-low.
REQ-004 in_valid  input  1  plaintext/key request valid.
REQ-005 in_ready  output  1  block accepts a request.
REQ-006 in_key  input  128  AES-128 cipher key, byte 0 in bits [127:120].
REQ-007 in_data  input  128  plaintext, same byte order.
REQ-008 out_valid  output  1  ciphertext valid.
REQ-009 out_ready  input  1  consumer accepts the ciphertext.
REQ-010 out_data  output  128  ciphertext.
REQ-011 busy  output  1  high in any state other than IDLE.
REQ-012 round_cnt  output  4  current round number, for debug.

Function
REQ-013 FSM states: IDLE, ROUND, FINAL, DONE; state is encoded in the package enum.
REQ-014 in_ready shall be 1 only in IDLE.
REQ-015 Accept occurs when in_valid && in_ready:
- state_reg <= in_data ^ in_key (round-0 AddRoundKey).
- key_reg <= in_key.
- round_cnt <= 1.
- FSM -> ROUND.
REQ-016 ROUND, each cycle:
- nk = key_step(key_reg, rcon[round_cnt]).
- key_reg <= nk.
- state_reg <= encrypt_round(state_reg, nk).
- round_cnt++.
- Leave for FINAL when round_cnt == 9 is processed.
REQ-017 FINAL, single cycle:
- nk = key_step(key_reg, rcon[10]).
- state_reg <= encrypt_final_round(state_reg, nk).
- round_cnt <= 10.
- FSM -> DONE.
REQ-018 Latency: accept edge E0; rounds 1..10 at edges E1..E10; out_valid=1 in the cycle after E10.
REQ-019 DONE: out_valid=1 and out_data=state_reg, both held stable until out_ready=1.
REQ-020 Output handshake (out_valid && out_ready): FSM -> IDLE, round_cnt <= 0; if ZEROIZE=1, state_reg and key_reg <= 0.
REQ-021 Minimum request-to-request period is 12 cycles; in_valid outside IDLE shall be ignored without side effects.
REQ-022 out_ready high before DONE shall have no effect.
REQ-023 in_key/in_data changes after acceptance shall not affect the result.
REQ-024 out_data shall be 0 whenever out_valid=0 and ZEROIZE=1; when ZEROIZE=0 it shall show state_reg unmasked.
REQ-025 rcon table: 01,02,04,08,10,20,40,80,1b,36 for rounds 1..10.
REQ-026 Key step: rotate word 3, apply SubWord, XOR rcon into the MSB, then chain XOR across words 0..3; all 128-bit XORs, no carries.

Reset
REQ-027 rst_n=0 at a clock edge shall force, in any state including mid-round:
- FSM=IDLE, round_cnt=0.
- state_reg=0, key_reg=0.
- out_valid=0, busy=0.
REQ-028 in_ready shall be 0 while rst_n=0 and 1 in the first cycle after deassertion.
REQ-029 An in-flight operation aborted by reset shall produce no out_valid.

Structure
REQ-030 Package aes_pkg shall hold:
- state enum (IDLE/ROUND/FINAL/DONE).
- NUM_ROUNDS=10.
- rcon table.
- S-box function shared with sub_bytes.
REQ-031 One sub-module, aes_key_step (combinational: key_in, rcon -> key_out), shall be instantiated once.
REQ-032 The block shall instantiate the existing encrypt_round and encrypt_final_round datapaths, one instance each; no other combinational logic shall sit on the state path except the round-0 XOR.
REQ-033 Target size 120-400 RTL lines, excluding the package.

Verification
REQ-034 FIPS-197 App. B: key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734 -> ct 3925841d02dc09fbdc118597196a0b32, out_valid first high exactly 11 cycles after the accept cycle.
REQ-035 FIPS-197 App. C.1: key 000102030405060708090a0b0c0d0e0f, pt 00112233445566778899aabbccddeeff -> 69c4e0d86a7b0430d8cdb78070b4c55a.
REQ-036 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and out_data stable; in_valid pulsed during that window -> ignored; the next accept occurs only after the handshake.
REQ-037 Reset at round 5 (rst_n=0 one cycle) -> next cycle IDLE, in_ready=1, round_cnt=0, no out_valid; a following App. B request gives the correct ct.
REQ-038 Back-to-back: in_valid held high with out_ready=1 -> two requests complete 12 cycles apart with correct ct each; in_data changed during processing -> no effect.
REQ-039 ZEROIZE=1: state_reg and key_reg = 0 one cycle after the handshake; ZEROIZE=0: key_reg retains the round-10 key (d014f9a8c9ee2589e13f0cc8b6630ca6 for App. B).
